// File: rtl/red_serial.sv
// Nibble-serial RED unit: sums the four signed bytes of A and B through one
// reused 4-bit ripple slice, with a start/busy/done handshake.
module red_serial #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result
);

  typedef enum logic [2:0] {IDLE, HI_L, HI_H, LO_L, LO_H, FIN} state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;
  logic [8:0]          sum_hi_reg;
  logic [8:0]          sum_lo_reg;
  logic                carry_reg;

  logic [SLICE_W-1:0]  nib_a;
  logic [SLICE_W-1:0]  nib_b;
  logic                slice_cin;
  logic [SLICE_W:0]    slice_c;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_msb;
  logic [9:0]          total;

  always_comb begin
    nib_a     = op_a_reg[3:0];
    nib_b     = op_b_reg[3:0];
    slice_cin = 1'b0;
    case (state_reg)
      HI_L: begin
        nib_a = op_a_reg[11:8];
        nib_b = op_b_reg[11:8];
      end
      HI_H: begin
        nib_a     = op_a_reg[15:12];
        nib_b     = op_b_reg[15:12];
        slice_cin = carry_reg;
      end
      LO_L: begin
        nib_a = op_a_reg[3:0];
        nib_b = op_b_reg[3:0];
      end
      LO_H: begin
        nib_a     = op_a_reg[7:4];
        nib_b     = op_b_reg[7:4];
        slice_cin = carry_reg;
      end
      default: ;
    endcase
  end

  // The shared ripple slice, one full adder per bit.
  assign slice_c[0] = slice_cin;
  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      assign slice_sum[gi]   = nib_a[gi] ^ nib_b[gi] ^ slice_c[gi];
      assign slice_c[gi+1]   = (nib_a[gi] & nib_b[gi]) | (slice_c[gi] & (nib_a[gi] ^ nib_b[gi]));
    end
  endgenerate

  // Bit 8 of a sign-extended 8-bit add: both operand signs xor the byte carry-out.
  assign slice_msb = nib_a[SLICE_W-1] ^ nib_b[SLICE_W-1] ^ slice_c[SLICE_W];
  assign total     = {sum_hi_reg[8], sum_hi_reg} + {sum_lo_reg[8], sum_lo_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Result     <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      sum_hi_reg <= '0;
      sum_lo_reg <= '0;
      carry_reg  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy <= start;
          if (start) begin
            op_a_reg  <= A;
            op_b_reg  <= B;
            state_reg <= HI_L;
          end
        end
        HI_L: begin
          sum_hi_reg[3:0] <= slice_sum;
          carry_reg       <= slice_c[SLICE_W];
          state_reg       <= HI_H;
        end
        HI_H: begin
          sum_hi_reg[8:4] <= {slice_msb, slice_sum};
          state_reg       <= LO_L;
        end
        LO_L: begin
          sum_lo_reg[3:0] <= slice_sum;
          carry_reg       <= slice_c[SLICE_W];
          state_reg       <= LO_H;
        end
        LO_H: begin
          sum_lo_reg[8:4] <= {slice_msb, slice_sum};
          state_reg       <= FIN;
        end
        FIN: begin
          // busy stays high through the done cycle; IDLE drops it next.
          Result    <= {{(DATA_W-10){total[9]}}, total};
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_serial.sv
// Self-checking bench for red_serial: directed cases plus randomized traffic
// compared every cycle against a countdown model of the RED unit.
module tb_red_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] Result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  red_serial #(.DATA_W(16), .SLICE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result)
  );

  function automatic logic [15:0] red_ref(input logic [15:0] a, input logic [15:0] b);
    byte ah, al, bh, bl;
    int  s;
    ah = a[15:8]; al = a[7:0]; bh = b[15:8]; bl = b[7:0];
    s = int'(ah) + int'(al) + int'(bh) + int'(bl);
    return s[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted op produces its sum 5 edges later; busy spans accept..done.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_res = 16'h0;
  logic [15:0] m_pend = 16'h0;
  int          m_cnt = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 16'h0; m_cnt = 0; chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        m_busy = start;
        if (start) begin
          m_cnt  = 5;
          m_pend = red_ref(A, B);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {15'h0, busy}, {15'h0, m_busy});
      chk("cyc_done", {15'h0, done}, {15'h0, m_done});
      chk("cyc_result", Result, m_res);
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string name);
    int n;
    @(negedge clk); A = a; B = b; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    $display("op %s A=%h B=%h Result=%h latency=%0d", name, a, b, Result, n);
    chk({name, "_latency"}, n[15:0], 16'd6);
    chk(name, Result, exp);
  endtask

  initial begin
    int ndone;
    int n;
    logic [15:0] first;

    // 1. reset held two edges with start high
    rst = 1'b1; start = 1'b1; A = 16'h0102; B = 16'h0304;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("reset_busy", {15'h0, busy}, 16'h0);
    chk("reset_done", {15'h0, done}, 16'h0);
    chk("reset_result", Result, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_no_accept", {15'h0, busy}, 16'h0);

    // 2, 3. basic and extremes
    run_op(16'h0102, 16'h0304, 16'h000A, "basic");
    run_op(16'h7F7F, 16'h7F7F, 16'h01FC, "max_pos");
    run_op(16'h8080, 16'h8080, 16'hFE00, "max_neg");

    // 4. mixed signs, operands churning and a stray start while busy
    @(negedge clk); A = 16'hFF01; B = 16'h0001; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("mixed_done_cycle", k[15:0], 16'd6);
      end
      start = (k == 2);
      A = 16'($urandom); B = 16'($urandom);
    end
    start = 1'b0;
    $display("op mixed A=ff01 B=0001 Result=%h dones=%0d", Result, ndone);
    chk("mixed_single_done", ndone[15:0], 16'd1);
    chk("mixed_result", Result, 16'h0001);

    // 5. back-to-back start in the done cycle
    run_op(16'h7F7F, 16'h7F7F, 16'h01FC, "b2b_first");
    first = Result;
    A = 16'h0000; B = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (done !== 1'b1 && n < 20) begin
      chk("b2b_hold", Result, first);
      @(negedge clk); n++;
    end
    $display("op b2b_second A=0000 B=ffff Result=%h latency=%0d", Result, n);
    chk("b2b_latency", n[15:0], 16'd6);
    chk("b2b_result", Result, 16'hFFFE);

    // 6. reset mid-operation, with start raised alongside it
    @(negedge clk); A = 16'h1234; B = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    $display("op abort Result=%h dones=%0d busy=%0d", Result, ndone, busy);
    chk("abort_no_done", ndone[15:0], 16'd0);
    chk("abort_result", Result, 16'h0000);
    chk("abort_busy", {15'h0, busy}, 16'h0);
    run_op(16'h0102, 16'h0304, 16'h000A, "after_abort");

    // randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      A = 16'($urandom); B = 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
